shift_reg_prescaled: RTL
========================

Name: shift_reg_prescaled

Overview:
Parametrised serial/parallel shift register advanced by an internal clock-enable prescaler, so no derived clock is ever used. It captures slow serial data (switches, sensor bits) into a WIDTH-bit bus, or shifts a parallel word out serially. It supports left/right shifting, parallel load, hold, frame completion signalling and synchronous clear. It sits between board I/O and display/LED logic, in the board's single clock domain.

Parameters:
WIDTH, 8, shift register and bus width (>=2)
PRESCALE, 4194304, clk cycles per shift tick (>=1); counter width is $clog2(PRESCALE), minimum 1

Ports:
clk  input  1  system clock; all logic on posedge
rst_n  input  1  asynchronous active-low reset
en  input  1  prescaler enable; 0 freezes the prescaler, so no ticks occur
clr  input  1  synchronous clear
mode  input  2  00 hold, 01 shift left, 10 shift right, 11 parallel load
ser_in  input  1  serial data in
par_in  input  WIDTH  parallel load word
out_bus  output  WIDTH  shift register contents
ser_out  output  1  last bit shifted out
tick  output  1  one-cycle prescaler tick strobe
frame_done  output  1  one-cycle pulse after WIDTH consecutive shifts
bit_cnt  output  $clog2(WIDTH+1)  shifts since last load, clear or frame

Behaviour:
- Reset (rst_n=0, async): out_bus=0, ser_out=0, tick=0, frame_done=0, bit_cnt=0, prescaler=0. All flops in one clk domain.
- Prescaler: counts 0..PRESCALE-1 when en=1.
  - At PRESCALE-1 it wraps to 0 and tick goes high for exactly one cycle (registered).
  - With PRESCALE=1, tick is high every cycle while en=1.
  - en=0 holds the count and forces tick=0.
- Register actions occur only in the cycle where tick=1; results are visible the next clk edge.
  - Latency: one clk after the tick cycle.
- mode 00: out_bus, bit_cnt and ser_out are unchanged.
- mode 01 (shift left): out_bus <= {out_bus[WIDTH-2:0], ser_in}; ser_out <= old out_bus[WIDTH-1].
- mode 10 (shift right): out_bus <= {ser_in, out_bus[WIDTH-1:1]}; ser_out <= old out_bus[0].
- mode 11 (load): out_bus <= par_in; bit_cnt <= 0; ser_out unchanged; no frame_done.
- bit_cnt on a shift:
  - Increments by 1.
  - If the pre-increment value is WIDTH-1, bit_cnt wraps to 0 and frame_done pulses high for one clk, coincident with the updated out_bus.
- Changing direction mid-frame does not reset bit_cnt; mixed-direction shifts count alike.
- frame_done is 0 in all other cycles.
- clr=1 has highest priority, above tick and mode:
  - Clears out_bus, ser_out, bit_cnt and the prescaler next edge.
  - Forces tick=0 and frame_done=0 that cycle.
  - A tick coinciding with clr is discarded.
- mode and ser_in are sampled only in the tick cycle; values between ticks are ignored.
- Reset mid-frame: everything returns to reset values immediately. After release, the first tick occurs PRESCALE cycles after the first enabled edge.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Use WIDTH=8, PRESCALE=4 for all scenarios.
- Reset/idle: rst_n=0 then release, en=1, mode=00 -> out_bus=0x00, and tick pulses once every 4 clk (cycles 4, 8, 12 after release) with no other output changes.
- Shift left frame: mode=01, ser_in per tick 1,0,1,1,0,0,1,0 -> out_bus=0xB2 after 8th tick. frame_done is a single 1-clk pulse with that update, and bit_cnt steps 1..7 then returns to 0.
- Load then shift right: mode=11, par_in=0xA5 on a tick -> out_bus=0xA5, bit_cnt=0. Then mode=10, ser_in=0 for 3 ticks -> out_bus 0x52, 0x29, 0x14 and ser_out 1, 0, 1.
- Enable freeze: drop en for 10 clk mid-count -> no tick during the gap, and the count resumes from its held value with the next tick spaced correctly.
- clr coincident with tick in mode=01 at bit_cnt=7 -> out_bus=0, bit_cnt=0, no frame_done, and the next tick arrives 4 clk after clr.
- Async reset mid-frame: assert rst_n=0 between clk edges with out_bus=0x3C -> all outputs go to 0 before the next posedge.

Source files
------------

// File: rtl/shift_reg_prescaled.sv
// shift_reg_prescaled
//
// Serial/parallel shift register advanced by an internal clock-enable
// prescaler. Everything runs on clk; the prescaler only produces a one-cycle
// tick strobe, and the register acts in the cycle where that strobe is high.
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst_n      asynchronous active-low reset
//   en         prescaler enable (0 freezes the count, no ticks)
//   clr        synchronous clear, highest priority
//   mode       00 hold, 01 shift left, 10 shift right, 11 parallel load
//   ser_in     serial data in
//   par_in     parallel load word
//   out_bus    shift register contents
//   ser_out    last bit shifted out
//   tick       one-cycle prescaler strobe (registered)
//   frame_done one-cycle pulse after WIDTH consecutive shifts
//   bit_cnt    shifts since last load, clear or frame
//
// Handshake: there is no valid/ready pair; mode/ser_in/par_in are sampled
// only on the clock edge that ends a cycle in which tick is high.

module shift_reg_prescaled #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 4194304
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       clr,
    input  logic [1:0]                 mode,
    input  logic                       ser_in,
    input  logic [WIDTH-1:0]           par_in,
    output logic [WIDTH-1:0]           out_bus,
    output logic                       ser_out,
    output logic                       tick,
    output logic                       frame_done,
    output logic [$clog2(WIDTH+1)-1:0] bit_cnt
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int BW = $clog2(WIDTH + 1);

    localparam logic [CW-1:0] CNT_MAX  = CW'(PRESCALE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_LEFT  = 2'b01;
    localparam logic [1:0] MODE_RIGHT = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    logic [CW-1:0]    cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic [WIDTH-1:0] bus_q, bus_d;
    logic             ser_q, ser_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             frame_done_q, frame_done_d;
    logic             shift_act;

    always_comb begin
        cnt_d        = cnt_q;
        tick_d       = 1'b0;
        bus_d        = bus_q;
        ser_d        = ser_q;
        bit_cnt_d    = bit_cnt_q;
        frame_done_d = 1'b0;
        shift_act    = 1'b0;

        if (clr) begin
            // Clear wins over everything, including a tick pending this cycle.
            cnt_d     = '0;
            bus_d     = '0;
            ser_d     = 1'b0;
            bit_cnt_d = '0;
        end else begin
            if (en) begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d  = '0;
                    tick_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            // The register acts on the edge that ends the tick cycle.
            if (tick_q) begin
                case (mode)
                    MODE_LEFT: begin
                        bus_d     = {bus_q[WIDTH-2:0], ser_in};
                        ser_d     = bus_q[WIDTH-1];
                        shift_act = 1'b1;
                    end
                    MODE_RIGHT: begin
                        bus_d     = {ser_in, bus_q[WIDTH-1:1]};
                        ser_d     = bus_q[0];
                        shift_act = 1'b1;
                    end
                    MODE_LOAD: begin
                        bus_d     = par_in;
                        bit_cnt_d = '0;
                    end
                    MODE_HOLD: begin
                    end
                    default: begin
                    end
                endcase
            end

            // Both directions count toward the same frame.
            if (shift_act) begin
                if (bit_cnt_q == BIT_LAST) begin
                    bit_cnt_d    = '0;
                    frame_done_d = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt_q + BW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            tick_q       <= 1'b0;
            bus_q        <= '0;
            ser_q        <= 1'b0;
            bit_cnt_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            tick_q       <= tick_d;
            bus_q        <= bus_d;
            ser_q        <= ser_d;
            bit_cnt_q    <= bit_cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign out_bus    = bus_q;
    assign ser_out    = ser_q;
    assign tick       = tick_q;
    assign frame_done = frame_done_q;
    assign bit_cnt    = bit_cnt_q;

endmodule
